i2s_tx_master: RTL and testbench

Clock-master I2S transmitter: takes stereo sample pairs from the DSP datapath over a valid/ready handshake and serializes them onto bck/lrck/sdout toward a DAC, generating bck and lrck itself from the system clock. It is the output-side counterpart of the I2S receive stage. It closes the input → DSP → output loop of the audio pipeline and also drives clocks for loopback tests into the receiver.

---
 rtl/i2s_tx_master.sv | 112 +++++++++++
 tb/tb_i2s_tx_master.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/i2s_tx_master.sv
// Clock-master I2S transmitter: a one-entry stereo holding register feeding
// L/R shift registers, serialized onto bck/lrck/sdout with a 1-bck MSB delay.
module i2s_tx_master #(
  parameter int unsigned WORD_SIZE = 24,
  parameter int unsigned SLOT_BITS = 32,
  parameter int unsigned BCK_DIV   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [WORD_SIZE-1:0] s_left,
  input  logic [WORD_SIZE-1:0] s_right,
  output logic                 bck,
  output logic                 lrck,
  output logic                 sdout,
  output logic                 underrun
);

  localparam int unsigned DivW = (BCK_DIV > 1) ? $clog2(BCK_DIV) : 1;
  localparam int unsigned BitW = $clog2(2 * SLOT_BITS);

  localparam logic [DivW-1:0] DivLast = DivW'(BCK_DIV - 1);
  localparam logic [DivW-1:0] DivHalf = DivW'(BCK_DIV / 2);
  localparam logic [BitW-1:0] BitLast = BitW'(2 * SLOT_BITS - 1);
  localparam logic [BitW-1:0] SlotLen = BitW'(SLOT_BITS);
  localparam logic [BitW-1:0] WordLen = BitW'(WORD_SIZE);

  logic [DivW-1:0]      div_cnt_q, div_cnt_d;
  logic [BitW-1:0]      bit_cnt_q, bit_cnt_d;
  logic                 bck_q, lrck_q, sdout_q, underrun_q;
  logic                 hold_full_q;
  logic [WORD_SIZE-1:0] hold_l_q, hold_r_q;
  logic [WORD_SIZE-1:0] sh_l_q, sh_r_q;

  logic            fe;
  logic            load;
  logic            write;
  logic            in_right;
  logic            data_slot;
  logic [BitW-1:0] pos;

  always_comb begin
    fe        = (div_cnt_q == DivLast);
    div_cnt_d = fe ? '0 : div_cnt_q + 1'b1;
    bit_cnt_d = (bit_cnt_q == BitLast) ? '0 : bit_cnt_q + 1'b1;
    // Slot decode uses the post-fe count so lrck/sdout land together on the bck fall.
    in_right  = (bit_cnt_d >= SlotLen);
    pos       = in_right ? bit_cnt_d - SlotLen : bit_cnt_d;
    data_slot = (pos != '0) && (pos <= WordLen);
    load      = fe && (bit_cnt_d == '0);
    write     = s_valid && !hold_full_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q   <= '0;
      bit_cnt_q   <= BitLast;
      bck_q       <= 1'b0;
      lrck_q      <= 1'b1;
      sdout_q     <= 1'b0;
      underrun_q  <= 1'b0;
      hold_full_q <= 1'b0;
      hold_l_q    <= '0;
      hold_r_q    <= '0;
      sh_l_q      <= '0;
      sh_r_q      <= '0;
    end else begin
      div_cnt_q  <= div_cnt_d;
      bck_q      <= (div_cnt_d >= DivHalf);
      underrun_q <= load && !hold_full_q;

      if (write) begin
        hold_l_q <= s_left;
        hold_r_q <= s_right;
      end
      // A write is only possible with hold empty, so it never races a consuming load.
      if (load && hold_full_q) begin
        hold_full_q <= 1'b0;
      end else if (write) begin
        hold_full_q <= 1'b1;
      end

      if (fe) begin
        bit_cnt_q <= bit_cnt_d;
        lrck_q    <= in_right;
        if (load) begin
          sh_l_q  <= hold_full_q ? hold_l_q : '0;
          sh_r_q  <= hold_full_q ? hold_r_q : '0;
          sdout_q <= 1'b0;
        end else if (data_slot) begin
          if (in_right) begin
            sdout_q <= sh_r_q[WORD_SIZE-1];
            sh_r_q  <= sh_r_q << 1;
          end else begin
            sdout_q <= sh_l_q[WORD_SIZE-1];
            sh_l_q  <= sh_l_q << 1;
          end
        end else begin
          sdout_q <= 1'b0;
        end
      end
    end
  end

  assign s_ready  = !hold_full_q;
  assign bck      = bck_q;
  assign lrck     = lrck_q;
  assign sdout    = sdout_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_i2s_tx_master.sv
// Bench for i2s_tx_master: frame-level reference model feeds an expected-frame
// queue; a DAC-style monitor decodes the serial stream and checks it.
module tb_i2s_tx_master;

  localparam int W     = 24;
  localparam int S     = 32;
  localparam int D     = 4;
  localparam int FRAME = 2 * S * D;

  typedef struct packed {
    logic [W-1:0] l;
    logic [W-1:0] r;
  } pair_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         s_valid;
  logic         s_ready;
  logic [W-1:0] s_left, s_right;
  logic         bck, lrck, sdout, underrun;

  i2s_tx_master #(
    .WORD_SIZE(W),
    .SLOT_BITS(S),
    .BCK_DIV  (D)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_left  (s_left),
    .s_right (s_right),
    .bck     (bck),
    .lrck    (lrck),
    .sdout   (sdout),
    .underrun(underrun)
  );

  always #5 clk = ~clk;

  int    total = 0;
  int    bad = 0;
  int    frames_checked = 0;
  pair_t exp_q[$];

  // Reference model state
  int           n;
  bit           m_full;
  logic [W-1:0] m_l, m_r;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (n=%0d t=%0t)", name, act, req, n, $time);
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_bck"}, 64'(bck), 64'(0));
    chk({tag, "_lrck"}, 64'(lrck), 64'(1));
    chk({tag, "_sdout"}, 64'(sdout), 64'(0));
    chk({tag, "_s_ready"}, 64'(s_ready), 64'(1));
    chk({tag, "_underrun"}, 64'(underrun), 64'(0));
  endtask

  // One clk: advance the model over the edge just taken, then check pin-level timing.
  task automatic step();
    bit load, acc, exp_under, exp_lr;
    int m, bitc;
    @(negedge clk);
    n++;
    load      = (n >= D) && (((n - D) % FRAME) == 0);
    acc       = s_valid && !m_full;
    exp_under = 1'b0;
    if (load) begin
      if (m_full) begin
        exp_q.push_back('{l: m_l, r: m_r});
        m_full = 1'b0;
      end else begin
        exp_q.push_back('{l: '0, r: '0});
        exp_under = 1'b1;
      end
    end
    if (acc) begin
      m_l    = s_left;
      m_r    = s_right;
      m_full = 1'b1;
    end
    m = n / D;
    bitc = (m == 0) ? 2 * S - 1 : (m - 1) % (2 * S);
    exp_lr = (bitc >= S);
    chk("underrun", 64'(underrun), 64'(exp_under));
    chk("s_ready", 64'(s_ready), 64'(!m_full));
    chk("bck", 64'(bck), 64'((n % D) >= D / 2));
    chk("lrck", 64'(lrck), 64'(exp_lr));
  endtask

  task automatic drive(input bit v, input logic [W-1:0] l, input logic [W-1:0] r);
    s_valid = v;
    s_left  = l;
    s_right = r;
  endtask

  task automatic drive_rand();
    drive(($urandom % 3) != 0, W'($urandom), W'($urandom));
  endtask

  // DAC-side monitor: sample lrck/sdout on each bck rise, rebuild words, compare per frame.
  initial begin
    bit           prev_bck, prev_lr, seen_left;
    int           idx, pad;
    logic [W-1:0] wl, wr;
    pair_t        e;
    prev_bck = 0; prev_lr = 1; seen_left = 0; idx = 0; pad = 0; wl = '0; wr = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_bck = 0; prev_lr = 1; seen_left = 0; idx = 0;
      end else begin
        if (bck && !prev_bck) begin
          if (lrck != prev_lr) idx = 0;
          else idx++;
          prev_lr = lrck;
          if (!lrck && idx == 0) begin
            seen_left = 1; wl = '0; wr = '0; pad = 0;
          end
          if (idx >= 1 && idx <= W) begin
            if (lrck) wr = {wr[W-2:0], sdout};
            else wl = {wl[W-2:0], sdout};
          end else if (sdout) begin
            pad++;
          end
          if (lrck && idx == S - 1 && seen_left) begin
            seen_left = 0;
            if (exp_q.size() == 0) begin
              total++;
              bad++;
              $display("FAIL frame_queue actual=empty required=entry (t=%0t)", $time);
            end else begin
              e = exp_q.pop_front();
              chk("frame_left", 64'(wl), 64'(e.l));
              chk("frame_right", 64'(wr), 64'(e.r));
              chk("frame_pad_zero", 64'(pad), 64'(0));
              frames_checked++;
            end
          end
        end
        prev_bck = bck;
      end
    end
  end

  initial begin
    n = 0; m_full = 0; m_l = '0; m_r = '0;
    rst_n = 1'b0;
    drive(0, '0, '0);
    repeat (3) @(negedge clk);
    chk_reset_outs("reset");

    rst_n = 1'b1;
    // Known pair before the first fe: expect it in frame 0, no underrun.
    drive(1, 24'h800001, 24'h7FFFFE);
    step();
    drive(0, '0, '0);
    // Frame 1 empty; write lands on the frame-1 load edge itself.
    while (n < D + FRAME - 1) step();
    drive(1, W'($urandom), W'($urandom));
    step();
    drive(0, '0, '0);
    while (n < D + 3 * FRAME + 8) step();

    // Randomised traffic with backpressure
    for (int i = 0; i < 10 * FRAME; i++) begin
      drive_rand();
      step();
    end
    while (((n - D) % FRAME) != FRAME / 4) begin
      drive_rand();
      step();
    end

    // Mid-frame asynchronous reset
    s_valid = 1'b1;
    rst_n   = 1'b0;
    #1;
    chk_reset_outs("async_reset");
    s_valid = 1'b0;
    m_full  = 0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    chk_reset_outs("held_reset");
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 4 * FRAME + D + 8; i++) begin
      drive_rand();
      step();
    end

    chk("frames_checked_min", 64'(frames_checked >= 15), 64'(1));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
